uart_apb_master: RTL and testbench

APB3 initiator (requester) that turns a simple valid/ready request into one APB3 transfer and returns the result over a valid/ready response channel. It is the other end of the APB3 port that the UART exposes. Uses: self-test sequencers, bridges (e.g. a future UART-command-to-APB bridge), and the bench driver for the UART register map. One transfer is outstanding at a time. A wait-state timeout guarantees that a hung responder cannot stall the requester.

---
 rtl/uart_apb_master.sv | 168 ++++++++++++++++
 tb/tb_uart_apb_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_master.sv
// APB3 requester: turns one valid/ready request into one APB3 transfer and
// returns the completion (data, slave error or wait-state timeout) on a response channel.
module uart_apb_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      i_apb_pclk,
    input  logic                      i_apb_presetn,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [APB_DATA_WIDTH-1:0] i_req_wdata,
    input  logic                      i_req_write,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic                      o_rsp_timeout,
    output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
    output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
    output logic                      o_apb_pwrite,
    output logic                      o_apb_psel,
    output logic                      o_apb_penable,
    input  logic                      i_apb_pready,
    input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
    input  logic                      i_apb_pslverr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;

    logic                      r_req_ready,   w_req_ready_nxt;
    logic [APB_ADDR_WIDTH-1:0] r_paddr,       w_paddr_nxt;
    logic [APB_DATA_WIDTH-1:0] r_pwdata,      w_pwdata_nxt;
    logic                      r_pwrite,      w_pwrite_nxt;
    logic                      r_psel,        w_psel_nxt;
    logic                      r_penable,     w_penable_nxt;
    logic                      r_rsp_valid,   w_rsp_valid_nxt;
    logic [APB_DATA_WIDTH-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic                      r_rsp_err,     w_rsp_err_nxt;
    logic                      r_rsp_timeout, w_rsp_timeout_nxt;

    logic                      w_timeout_hit;

    // The counter holds the number of pready-low ACCESS cycles already spent.
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_req_ready_nxt   = r_req_ready;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_pwrite_nxt      = r_pwrite;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;

        case (r_state)
            S_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (i_req_valid && r_req_ready) begin
                    w_paddr_nxt     = i_req_addr;
                    w_pwdata_nxt    = i_req_wdata;
                    w_pwrite_nxt    = i_req_write;
                    w_psel_nxt      = 1'b1;
                    w_req_ready_nxt = 1'b0;
                    w_state_nxt     = S_SETUP;
                end
            end
            S_SETUP: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_state_nxt   = S_ACCESS;
            end
            S_ACCESS: begin
                if (i_apb_pready) begin
                    w_rsp_rdata_nxt   = r_pwrite ? '0 : i_apb_prdata;
                    w_rsp_err_nxt     = i_apb_pslverr;
                    w_rsp_timeout_nxt = 1'b0;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else if (w_timeout_hit) begin
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_req_ready   <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_apb_paddr   = r_paddr;
    assign o_apb_pwdata  = r_pwdata;
    assign o_apb_pwrite  = r_pwrite;
    assign o_apb_psel    = r_psel;
    assign o_apb_penable = r_penable;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_rdata   = r_rsp_rdata;
    assign o_rsp_err     = r_rsp_err;
    assign o_rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_uart_apb_master.sv
// Bench for uart_apb_master: each transaction is expanded into a cycle timeline of
// expected outputs, which one negedge process compares against the DUT.
module tb_uart_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req_valid, o_req_ready, i_req_write;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_req_wdata;
    logic          o_rsp_valid, i_rsp_ready, o_rsp_err, o_rsp_timeout;
    logic [DW-1:0] o_rsp_rdata;
    logic [AW-1:0] o_apb_paddr;
    logic [DW-1:0] o_apb_pwdata, i_apb_prdata;
    logic          o_apb_pwrite, o_apb_psel, o_apb_penable, i_apb_pready, i_apb_pslverr;

    always #5 clk = ~clk;

    uart_apb_master #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_apb_pclk   (clk),
        .i_apb_presetn(rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .i_req_write  (i_req_write),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_timeout(o_rsp_timeout),
        .o_apb_paddr  (o_apb_paddr),
        .o_apb_pwdata (o_apb_pwdata),
        .o_apb_pwrite (o_apb_pwrite),
        .o_apb_psel   (o_apb_psel),
        .o_apb_penable(o_apb_penable),
        .i_apb_pready (i_apb_pready),
        .i_apb_prdata (i_apb_prdata),
        .i_apb_pslverr(i_apb_pslverr)
    );

    typedef struct {
        logic [31:0] addr, wdata, prdata;
        logic        write, perr, rst;
        int unsigned w, b, gap;
    } tx_t;

    typedef struct {
        logic        req_ready, psel, pen, rsp_valid, write, err, to;
        logic [31:0] addr, wdata, rdata;
    } exp_t;

    tx_t   txq[$];
    exp_t  ex;
    bit    ex_v = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    cur_tx = -1;
    int    acc_cyc[0:255];
    int    rsp_cyc[0:255];
    logic [31:0] rsp_rd[0:255];
    logic  rsp_er[0:255];
    logic  rsp_to[0:255];
    logic  prev_rv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    // Single compare process: checks every cycle the timeline marks as meaningful.
    always @(negedge clk) begin
        if (ex_v) begin
            chk("req_ready", o_req_ready, ex.req_ready);
            chk("psel", o_apb_psel, ex.psel);
            chk("penable", o_apb_penable, ex.pen);
            chk("rsp_valid", o_rsp_valid, ex.rsp_valid);
            if (ex.psel) begin
                chk("paddr", o_apb_paddr, ex.addr);
                chk("pwdata", o_apb_pwdata, ex.wdata);
                chk("pwrite", o_apb_pwrite, ex.write);
            end
            if (ex.rsp_valid) begin
                chk("rsp_rdata", o_rsp_rdata, ex.rdata);
                chk("rsp_err", o_rsp_err, ex.err);
                chk("rsp_timeout", o_rsp_timeout, ex.to);
            end
        end
        if (o_rsp_valid && !prev_rv && cur_tx >= 0 && cur_tx < 256) begin
            rsp_cyc[cur_tx] = cyc;
            rsp_rd[cur_tx]  = o_rsp_rdata;
            rsp_er[cur_tx]  = o_rsp_err;
            rsp_to[cur_tx]  = o_rsp_timeout;
        end
        prev_rv = o_rsp_valid;
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e.req_ready = 1'b1; e.psel = 1'b0; e.pen = 1'b0; e.rsp_valid = 1'b0;
        e.write = 1'b0; e.err = 1'b0; e.to = 1'b0;
        e.addr = '0; e.wdata = '0; e.rdata = '0;
        return e;
    endfunction

    function automatic tx_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic write, input int unsigned w,
                               input logic [31:0] prdata, input logic perr,
                               input int unsigned b, input int unsigned gap, input logic rst);
        tx_t t;
        t.addr = addr; t.wdata = wdata; t.write = write; t.w = w; t.prdata = prdata;
        t.perr = perr; t.b = b; t.gap = gap; t.rst = rst;
        return t;
    endfunction

    task automatic step(input logic rv, input logic [31:0] ra, input logic [31:0] rwd,
                        input logic rwr, input logic pr, input logic [31:0] prd,
                        input logic pe, input logic rr, input exp_t e);
        @(posedge clk);
        #1;
        i_req_valid = rv; i_req_addr = ra; i_req_wdata = rwd; i_req_write = rwr;
        i_apb_pready = pr; i_apb_prdata = prd; i_apb_pslverr = pe; i_rsp_ready = rr;
        ex = e;
        ex_v = 1'b1;
        cyc++;
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic run_tx(input int k);
        tx_t         t;
        tx_t         n;
        bit          has_nx;
        bit          tmo;
        int unsigned n_acc;
        exp_t        e;
        bit          last;
        t      = txq[k];
        has_nx = (k + 1 < txq.size());
        n      = has_nx ? txq[k+1] : mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tmo    = (T != 0) && (t.w >= T);
        n_acc  = tmo ? T : t.w + 1;

        repeat (t.gap) step(1'b0, $urandom, $urandom, rb(), rb(), $urandom, rb(), rb(), idle_exp());

        step(1'b1, t.addr, t.wdata, t.write, rb(), $urandom, rb(), rb(), idle_exp());
        acc_cyc[k] = cyc;
        cur_tx = k;

        e = idle_exp();
        e.req_ready = 1'b0; e.psel = 1'b1; e.addr = t.addr; e.wdata = t.wdata; e.write = t.write;
        step(rb(), $urandom, $urandom, rb(), rb(), $urandom, rb(), rb(), e);

        e.pen = 1'b1;
        for (int unsigned j = 0; j < n_acc; j++) begin
            last = !tmo && (j == n_acc - 1);
            step(rb(), $urandom, $urandom, rb(), last, last ? t.prdata : $urandom,
                 last ? t.perr : rb(), rb(), e);
            if (t.rst && j == 1) begin
                ex_v = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("rst_async_ctrl", {o_req_ready, o_apb_psel, o_apb_penable, o_rsp_valid,
                                       o_rsp_err, o_rsp_timeout, o_apb_pwrite}, 0);
                chk("rst_async_data", {o_apb_paddr, o_rsp_rdata}, 0);
                chk("rst_async_pwdata", o_apb_pwdata, 0);
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b1;
                #1 chk("rst_release_ready_low", o_req_ready, 0);
                return;
            end
        end

        e = idle_exp();
        e.req_ready = 1'b0; e.rsp_valid = 1'b1; e.to = tmo; e.err = tmo ? 1'b1 : t.perr;
        e.rdata = (tmo || t.write) ? 32'h0 : t.prdata;
        for (int unsigned r = 0; r <= t.b; r++) begin
            step(has_nx && n.gap == 0, n.addr, n.wdata, n.write, rb(), $urandom, rb(),
                 r == t.b, e);
        end
    endtask

    initial begin
        int unsigned sel;
        int unsigned w;
        for (int i = 0; i < 256; i++) begin
            rsp_cyc[i] = -1;
            acc_cyc[i] = -1;
        end
        i_req_valid = 0; i_req_addr = 0; i_req_wdata = 0; i_req_write = 0;
        i_apb_pready = 0; i_apb_prdata = 0; i_apb_pslverr = 0; i_rsp_ready = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ctrl", {o_req_ready, o_apb_psel, o_apb_penable, o_rsp_valid,
                           o_rsp_err, o_rsp_timeout, o_apb_pwrite}, 0);
        chk("reset_data", {o_apb_paddr, o_rsp_rdata}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("reset_release_ready_low", o_req_ready, 0);

        txq.push_back(mk(32'h0000_0010, 32'hA5A5_0001, 1, 0,  32'h1111_2222, 0, 0, 0, 0));
        txq.push_back(mk(32'h0000_0004, 32'h0,         0, 3,  32'h1234_5678, 0, 0, 1, 0));
        txq.push_back(mk(32'h0000_0008, 32'h0,         0, 0,  32'hDEAD_BEEF, 1, 0, 0, 0));
        txq.push_back(mk(32'h0000_000C, 32'h0,         0, T,  32'h5555_AAAA, 0, 0, 0, 0));
        txq.push_back(mk(32'h0000_0014, 32'h0,         0, T-1, 32'hCAFE_F00D, 0, 0, 2, 0));
        txq.push_back(mk(32'h0000_0018, 32'h0BAD_0002, 1, 0,  32'h0,         0, 5, 0, 0));
        txq.push_back(mk(32'h0000_001C, 32'h0,         0, 1,  32'h7777_0001, 0, 0, 0, 0));
        txq.push_back(mk(32'h0000_0020, 32'h0,         0, 10, 32'h0,         0, 0, 0, 1));
        txq.push_back(mk(32'h0000_0024, 32'h0C0F_FEE0, 1, 0,  32'h0,         0, 0, 0, 0));
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            w = (sel < 7) ? $urandom_range(0, 4) : $urandom_range(T - 2, T + 1);
            txq.push_back(mk($urandom, $urandom, rb(), w, $urandom, rb(),
                             $urandom_range(0, 3), $urandom_range(0, 2), 1'b0));
        end

        for (int k = 0; k < txq.size(); k++) run_tx(k);
        repeat (3) step(1'b0, 0, 0, 0, rb(), $urandom, rb(), rb(), idle_exp());
        @(posedge clk);
        #1 ex_v = 1'b0;

        chk("wr0_latency", rsp_cyc[0] - acc_cyc[0], 3);
        chk("wr0_rdata", rsp_rd[0], 32'h0);
        chk("wr0_err", {rsp_er[0], rsp_to[0]}, 2'b00);
        chk("rd3w_latency", rsp_cyc[1] - acc_cyc[1], 6);
        chk("rd3w_rdata", rsp_rd[1], 32'h1234_5678);
        chk("slverr_flags", {rsp_er[2], rsp_to[2]}, 2'b10);
        chk("slverr_rdata", rsp_rd[2], 32'hDEAD_BEEF);
        chk("tmo_latency", rsp_cyc[3] - acc_cyc[3], 18);
        chk("tmo_flags", {rsp_er[3], rsp_to[3]}, 2'b11);
        chk("tmo_rdata", rsp_rd[3], 32'h0);
        chk("tmo_edge_latency", rsp_cyc[4] - acc_cyc[4], 18);
        chk("tmo_edge_flags", {rsp_er[4], rsp_to[4]}, 2'b00);
        chk("tmo_edge_rdata", rsp_rd[4], 32'hCAFE_F00D);
        chk("backpressure_next_accept", acc_cyc[6] - rsp_cyc[5], 6);
        chk("reset_no_rsp", rsp_cyc[7], -1);
        chk("post_reset_rsp_latency", rsp_cyc[8] - acc_cyc[8], 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
